// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32I-subset controller
package ctrl_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
  } state_t;
  typedef enum logic [1:0] {K_R, K_I, K_B} kind_t;
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps instruction kind and funct fields to an ALU op and a legality flag
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  kind_t      kind,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctr,
  output logic       legal
);
  // branches compare via SUB/SLT; R/I share the funct3 map, SUB only for R (bit 30 is immediate in I)
  always_comb begin
    alu_ctr = ALU_ADD;
    legal = 1'b1;
    if (kind == K_B) begin
      alu_ctr = funct3 == 3'b100 ? ALU_SLT : ALU_SUB;
      legal = funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100;
    end else begin
      case (funct3)
        3'b000: alu_ctr = kind == K_R && funct7b5 ? ALU_SUB : ALU_ADD;
        3'b001: alu_ctr = ALU_SLL;
        3'b010: alu_ctr = ALU_SLT;
        3'b011: legal = 1'b0;
        3'b100: alu_ctr = ALU_XOR;
        3'b101: begin
          alu_ctr = ALU_SRL;
          legal = !funct7b5;
        end
        3'b110: alu_ctr = ALU_OR;
        default: alu_ctr = ALU_AND;
      endcase
    end
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I-subset control FSM driving datapath selects and memory handshake
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [3:0] alu_ctr,
  output logic       trap
);
  state_t state, state_nx;
  kind_t kind;
  logic [3:0] dec_ctr;
  logic dec_legal;
  assign kind = opcode == OP_I ? K_I : opcode == OP_BRANCH ? K_B : K_R;
  alu_op_decoder u_dec (
    .kind(kind),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .alu_ctr(dec_ctr),
    .legal(dec_legal)
  );
  // state register; reset aborts any in-flight access
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= S_FETCH;
    else state <= state_nx;
  // next-state: memory states wait on mem_ready, illegal encodings caught in DECODE
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: state_nx = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEM_ADDR;
          OP_R: state_nx = dec_legal ? S_EXEC_R : S_TRAP;
          OP_I: state_nx = dec_legal ? S_EXEC_I : S_TRAP;
          OP_BRANCH: state_nx = dec_legal ? S_BRANCH : S_TRAP;
          OP_JAL: state_nx = S_JAL;
          default: state_nx = S_TRAP;
        endcase
      S_MEM_ADDR: state_nx = opcode == OP_STORE ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: state_nx = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_nx = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R, S_EXEC_I, S_JAL: state_nx = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH: state_nx = S_FETCH;
      S_TRAP: state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
  end
  // output decode from state; forced to zero while reset is held so a pending request drops at once
  always_comb begin
    mem_req = 1'b0;
    mem_write = 1'b0;
    adr_src = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RS2;
    result_src = RES_ALUOUT;
    alu_ctr = ALU_ADD;
    trap = 1'b0;
    if (resetn)
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          alu_src_b = mem_ready ? SRC_B_FOUR : SRC_B_RS2;
          result_src = mem_ready ? RES_ALU : RES_ALUOUT;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEM_WB: begin
          result_src = RES_MEM;
          reg_write = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req = 1'b1;
          mem_write = 1'b1;
          adr_src = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_ctr = dec_ctr;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_ctr = dec_ctr;
        end
        S_ALU_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = SRC_A_RS1;
          alu_ctr = dec_ctr;
          pc_write = funct3 == 3'b000 ? zero : !zero;
        end
        S_JAL: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_FOUR;
          pc_write = 1'b1;
        end
        S_TRAP: trap = 1'b1;
        default: trap = 1'b0;
      endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_ctr;
  logic [17:0] got;
  typedef struct {
    logic [17:0] v;
    string nm;
  } exp_t;
  exp_t q[$];
  int total = 0, passed = 0;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, LUI = 7'b0110111;
  logic [17:0] z_o, fw, fr, dec, ma, mrd, mwb, mwr, awb, jal_o, tr;

  multicycle_ctrl dut (
    .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_ctr(alu_ctr), .trap(trap)
  );
  assign got = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_ctr, trap};

  always #5 clk = ~clk;

  function automatic logic [17:0] o(input logic mq, mw, ad, iw, pw, rw,
                                    input logic [1:0] a, b, rs, input logic [3:0] c, input logic t);
    return {mq, mw, ad, iw, pw, rw, a, b, rs, c, t};
  endfunction

  // monitor: one expected output vector per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (got !== e.v)
        $display("FAIL %s: got %b expected %b at %0t", e.nm, got, e.v, $time);
      else
        passed++;
    end
  end

  task automatic step(input logic rn, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic zf, input logic mr,
                      input logic [17:0] ev, input string nm);
    exp_t e;
    resetn = rn;
    opcode = op;
    funct3 = f3;
    funct7b5 = f7;
    zero = zf;
    mem_ready = mr;
    e.v = ev;
    e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    z_o = '0;
    fw = o(1,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,0);
    fr = o(1,0,0,1,1,0,2'd0,2'd2,2'd2,4'd0,0);
    dec = o(0,0,0,0,0,0,2'd1,2'd1,2'd0,4'd0,0);
    ma = o(0,0,0,0,0,0,2'd2,2'd1,2'd0,4'd0,0);
    mrd = o(1,0,1,0,0,0,2'd0,2'd0,2'd0,4'd0,0);
    mwb = o(0,0,0,0,0,1,2'd0,2'd0,2'd1,4'd0,0);
    mwr = o(1,1,1,0,0,0,2'd0,2'd0,2'd0,4'd0,0);
    awb = o(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,0);
    jal_o = o(0,0,0,0,1,0,2'd1,2'd2,2'd0,4'd0,0);
    tr = o(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,1);
    @(posedge clk);
    #1;
    step(0, R, 3'b000, 0, 0, 1, z_o, "reset_outputs");
    // add
    step(1, R, 3'b000, 0, 0, 1, fr, "add_fetch");
    step(1, R, 3'b000, 0, 0, 1, dec, "add_decode");
    step(1, R, 3'b000, 0, 0, 1, o(0,0,0,0,0,0,2'd2,2'd0,2'd0,4'b0000,0), "add_exec");
    step(1, R, 3'b000, 0, 0, 1, awb, "add_wb");
    // sub
    step(1, R, 3'b000, 1, 0, 1, fr, "sub_fetch");
    step(1, R, 3'b000, 1, 0, 1, dec, "sub_decode");
    step(1, R, 3'b000, 1, 0, 1, o(0,0,0,0,0,0,2'd2,2'd0,2'd0,4'b0001,0), "sub_exec");
    step(1, R, 3'b000, 1, 0, 1, awb, "sub_wb");
    // slti, with a fetch wait cycle
    step(1, I, 3'b010, 0, 0, 0, fw, "slti_fetch_wait");
    step(1, I, 3'b010, 0, 0, 1, fr, "slti_fetch");
    step(1, I, 3'b010, 0, 0, 1, dec, "slti_decode");
    step(1, I, 3'b010, 0, 0, 1, o(0,0,0,0,0,0,2'd2,2'd1,2'd0,4'b0111,0), "slti_exec");
    step(1, I, 3'b010, 0, 0, 1, awb, "slti_wb");
    // xor R-type
    step(1, R, 3'b100, 0, 0, 1, fr, "xor_fetch");
    step(1, R, 3'b100, 0, 0, 1, dec, "xor_decode");
    step(1, R, 3'b100, 0, 0, 1, o(0,0,0,0,0,0,2'd2,2'd0,2'd0,4'b0100,0), "xor_exec");
    step(1, R, 3'b100, 0, 0, 1, awb, "xor_wb");
    // lw with 3 wait cycles
    step(1, LD, 3'b010, 0, 0, 1, fr, "lw_fetch");
    step(1, LD, 3'b010, 0, 0, 1, dec, "lw_decode");
    step(1, LD, 3'b010, 0, 0, 1, ma, "lw_addr");
    for (int k = 0; k < 3; k++) step(1, LD, 3'b010, 0, 0, 0, mrd, "lw_read_wait");
    step(1, LD, 3'b010, 0, 0, 1, mrd, "lw_read_ready");
    step(1, LD, 3'b010, 0, 0, 1, mwb, "lw_wb");
    // sw 0-wait
    step(1, ST, 3'b010, 0, 0, 1, fr, "sw_fetch");
    step(1, ST, 3'b010, 0, 0, 1, dec, "sw_decode");
    step(1, ST, 3'b010, 0, 0, 1, ma, "sw_addr");
    step(1, ST, 3'b010, 0, 0, 1, mwr, "sw_write");
    // branches
    step(1, BR, 3'b000, 0, 1, 1, fr, "beq_t_fetch");
    step(1, BR, 3'b000, 0, 1, 1, dec, "beq_t_decode");
    step(1, BR, 3'b000, 0, 1, 1, o(0,0,0,0,1,0,2'd2,2'd0,2'd0,4'b0001,0), "beq_taken");
    step(1, BR, 3'b000, 0, 0, 1, fr, "beq_n_fetch");
    step(1, BR, 3'b000, 0, 0, 1, dec, "beq_n_decode");
    step(1, BR, 3'b000, 0, 0, 1, o(0,0,0,0,0,0,2'd2,2'd0,2'd0,4'b0001,0), "beq_not_taken");
    step(1, BR, 3'b001, 0, 1, 1, fr, "bne_fetch");
    step(1, BR, 3'b001, 0, 1, 1, dec, "bne_decode");
    step(1, BR, 3'b001, 0, 1, 1, o(0,0,0,0,0,0,2'd2,2'd0,2'd0,4'b0001,0), "bne_not_taken");
    step(1, BR, 3'b100, 0, 0, 1, fr, "blt_fetch");
    step(1, BR, 3'b100, 0, 0, 1, dec, "blt_decode");
    step(1, BR, 3'b100, 0, 0, 1, o(0,0,0,0,1,0,2'd2,2'd0,2'd0,4'b0111,0), "blt_taken");
    // jal
    step(1, JL, 3'b000, 0, 0, 1, fr, "jal_fetch");
    step(1, JL, 3'b000, 0, 0, 1, dec, "jal_decode");
    step(1, JL, 3'b000, 0, 0, 1, jal_o, "jal_exec");
    step(1, JL, 3'b000, 0, 0, 1, awb, "jal_wb");
    // illegal opcode: sticky trap, then reset clears
    step(1, LUI, 3'b000, 0, 0, 1, fr, "lui_fetch");
    step(1, LUI, 3'b000, 0, 0, 1, dec, "lui_decode");
    for (int k = 0; k < 10; k++) step(1, LUI, 3'b000, 0, 0, k[0], tr, "lui_trap_hold");
    step(0, LUI, 3'b000, 0, 0, 1, z_o, "trap_reset");
    // srai illegal
    step(1, I, 3'b101, 1, 0, 1, fr, "srai_fetch");
    step(1, I, 3'b101, 1, 0, 1, dec, "srai_decode");
    step(1, I, 3'b101, 1, 0, 1, tr, "srai_trap");
    step(1, I, 3'b101, 1, 0, 0, tr, "srai_trap_hold");
    step(0, I, 3'b101, 1, 0, 0, z_o, "srai_reset");
    // srli legal
    step(1, I, 3'b101, 0, 0, 1, fr, "srli_fetch");
    step(1, I, 3'b101, 0, 0, 1, dec, "srli_decode");
    step(1, I, 3'b101, 0, 0, 1, o(0,0,0,0,0,0,2'd2,2'd1,2'd0,4'b0110,0), "srli_exec");
    step(1, I, 3'b101, 0, 0, 1, awb, "srli_wb");
    // reset asserted mid store wait
    step(1, ST, 3'b010, 0, 0, 1, fr, "sw2_fetch");
    step(1, ST, 3'b010, 0, 0, 1, dec, "sw2_decode");
    step(1, ST, 3'b010, 0, 0, 1, ma, "sw2_addr");
    step(1, ST, 3'b010, 0, 0, 0, mwr, "sw2_write_wait");
    step(0, ST, 3'b010, 0, 0, 0, z_o, "sw2_reset_abort");
    step(1, ST, 3'b010, 0, 0, 0, fw, "post_reset_fetch");
    step(1, ST, 3'b010, 0, 0, 0, fw, "post_reset_fetch_hold");
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
